// File: rtl/ctrl_decode_stage.sv
// RV32 decode/control stage: registered decode with load-use
// interlock, valid/ready backpressure, flush and optional M decode.
module ctrl_decode_stage #(
  parameter int XLEN     = 32,
  parameter int HAS_MEXT = 1,
  parameter int ALUOP_W  = 5,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [4:0]         out_rd,
  output logic [XLEN-1:0]    out_imm,
  output logic [ALUOP_W-1:0] out_aluop,
  output logic [13:0]        out_ctrl,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];
  assign rd  = in_instr[11:7];

  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25],
                  in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31],
                  in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31],
                  in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  function automatic logic [4:0] alu_base(
    input logic [2:0] fn
  );
    logic [4:0] op;
    op = 5'd0;
    case (fn)
      3'b000:  op = 5'b00000;
      3'b001:  op = 5'b00101;
      3'b010:  op = 5'b01000;
      3'b011:  op = 5'b01001;
      3'b100:  op = 5'b00010;
      3'b101:  op = 5'b00110;
      3'b110:  op = 5'b00011;
      default: op = 5'b00100;
    endcase
    return op;
  endfunction

  logic [13:0] ctrl_raw;
  logic [13:0] dec_ctrl;
  logic [4:0]  op_raw;
  logic [4:0]  dec_op;
  logic [31:0] imm32;
  logic        dec_ill;

  always_comb begin
    ctrl_raw = '0;
    op_raw   = '0;
    imm32    = '0;
    dec_ill  = 1'b0;
    unique case (1'b1)
      (opc == OPC_OP): begin
        ctrl_raw[11]  = 1'b1;
        ctrl_raw[12]  = 1'b1;
        ctrl_raw[4]   = 1'b1;
        ctrl_raw[6:5] = 2'b10;
        if (f7 == F7_MEXT) begin
          if (HAS_MEXT != 0) begin
            op_raw       = {2'b10, f3};
            ctrl_raw[13] = 1'b1;
          end else begin
            dec_ill = 1'b1;
          end
        end else if (f7 == F7_BASE) begin
          op_raw = alu_base(f3);
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          op_raw = 5'b00001;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          op_raw = 5'b00111;
        end else begin
          dec_ill = 1'b1;
        end
      end
      (opc == OPC_OPIMM): begin
        ctrl_raw[0]   = 1'b1;
        ctrl_raw[11]  = 1'b1;
        ctrl_raw[4]   = 1'b1;
        ctrl_raw[6:5] = 2'b10;
        imm32         = imm_i;
        op_raw        = alu_base(f3);
        // Only shifts carry a funct7; other immediates use those bits
        if (f3 == 3'b001 || f3 == 3'b101) begin
          if (f7 == F7_ALT && f3 == 3'b101) begin
            op_raw = 5'b00111;
          end else if (f7 != F7_BASE && f7 != F7_ALT) begin
            dec_ill = 1'b1;
          end
        end
      end
      (opc == OPC_BRANCH): begin
        ctrl_raw[11] = 1'b1;
        ctrl_raw[12] = 1'b1;
        ctrl_raw[1]  = 1'b1;
        imm32        = imm_b;
        op_raw       = (f3[2:1] == 2'b11) ? 5'b01001
                                          : 5'b01000;
        if (f3[2:1] == 2'b01) begin
          dec_ill = 1'b1;
        end
      end
      (opc == OPC_LOAD): begin
        ctrl_raw[11]  = 1'b1;
        ctrl_raw[4]   = 1'b1;
        ctrl_raw[0]   = 1'b1;
        ctrl_raw[2]   = 1'b1;
        ctrl_raw[6:5] = 2'b01;
        imm32         = imm_i;
      end
      (opc == OPC_STORE): begin
        ctrl_raw[11] = 1'b1;
        ctrl_raw[12] = 1'b1;
        ctrl_raw[0]  = 1'b1;
        ctrl_raw[3]  = 1'b1;
        imm32        = imm_s;
      end
      (opc == OPC_JAL): begin
        ctrl_raw[9] = 1'b1;
        ctrl_raw[4] = 1'b1;
        ctrl_raw[0] = 1'b1;
        imm32       = imm_j;
      end
      (opc == OPC_JALR): begin
        ctrl_raw[11] = 1'b1;
        ctrl_raw[9]  = 1'b1;
        ctrl_raw[4]  = 1'b1;
        ctrl_raw[0]  = 1'b1;
        ctrl_raw[7]  = 1'b1;
        imm32        = imm_i;
      end
      (opc == OPC_LUI): begin
        ctrl_raw[10]  = 1'b1;
        ctrl_raw[4]   = 1'b1;
        ctrl_raw[0]   = 1'b1;
        ctrl_raw[6:5] = 2'b10;
        imm32         = imm_u;
      end
      (opc == OPC_AUIPC): begin
        ctrl_raw[8] = 1'b1;
        ctrl_raw[4] = 1'b1;
        ctrl_raw[0] = 1'b1;
        imm32       = imm_u;
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
  end

  always_comb begin
    dec_ctrl = ctrl_raw;
    dec_op   = op_raw;
    if (dec_ill) begin
      dec_ctrl = '0;
      dec_op   = '0;
    end
    if (rd == 5'd0) begin
      dec_ctrl[4] = 1'b0;
    end
  end

  logic hazard;
  logic fire_in;
  logic fire_out;

  // Load in the output register feeding a source of the offered instr
  assign hazard = out_valid & out_ctrl[2] & (out_rd != 5'd0) &
                  ((dec_ctrl[11] & (rs1 == out_rd)) |
                   (dec_ctrl[12] & (rs2 == out_rd)));

  assign in_ready = (!out_valid | out_ready) & !hazard &
                    !flush & !rst;
  assign fire_in  = in_valid & in_ready;
  assign fire_out = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_imm     <= '0;
      out_aluop   <= '0;
      out_ctrl    <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire_in) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_rs1     <= rs1;
      out_rs2     <= rs2;
      out_rd      <= rd;
      out_imm     <= XLEN'($signed(imm32));
      out_aluop   <= ALUOP_W'(dec_op);
      out_ctrl    <= dec_ctrl;
      out_illegal <= dec_ill;
    end else if (fire_out) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && hazard && !flush &&
                 stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
Registered instruction decode/control stage for the pipelined RV32 core. It sits between the fetch buffer and the execute stage.
- Decodes opcode/funct3/funct7 into the ALU op and control bundle, extracts register indices and the sign-extended immediate.
- Optionally decodes the M extension and flags illegal encodings.
- Enforces the load-use interlock with a one-bubble stall, and supports valid/ready backpressure and flush.

Parameters:
XLEN, 32, datapath width; immediate sign-extended to XLEN; must be >= 32.
HAS_MEXT, 1, 1 = decode MUL/DIV (funct7=0000001 on OP); 0 = such encodings are illegal.
ALUOP_W, 5, ALU op width; must be >= 5 when HAS_MEXT=1, >= 4 otherwise.
CNT_W, 16, width of the interlock stall counter.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage accepts in_instr this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  PC of in_instr
flush  in  1  kill the instruction held in the stage and any instruction offered this cycle
out_valid  out  1  decoded instruction available
out_ready  in  1  execute accepts the output
out_pc  out  XLEN  registered PC
out_rs1 / out_rs2 / out_rd  out  5 each  register indices
out_imm  out  XLEN  sign-extended immediate
out_aluop  out  ALUOP_W  ALU operation
out_ctrl  out  14  bit0 immsrc, 1 isbranch, 2 memread, 3 memwrite, 4 regwrite, 6:5 memtoreg, 7 pcsel, 8 rdsel, 9 isjump, 10 islui, 11 use_rs1, 12 use_rs2, 13 is_mdu
out_illegal  out  1  unsupported opcode/encoding
stall_cnt  out  CNT_W  count of interlock stall cycles

Behaviour:
- Reset (sync, rst=1 at posedge): out_valid=0; out_pc, out_rs*, out_rd, out_imm, out_aluop, out_ctrl, out_illegal = 0; stall_cnt=0. Reset overrides flush and any handshake in the same cycle. in_ready=0 while rst=1.
- Single-entry output register. Latency 1: an instruction accepted at edge N appears at out_* with out_valid=1 after edge N.
- Output handshakes:
  - fire_out = out_valid & out_ready.
  - Outputs are held stable while out_valid=1 and out_ready=0.
- hazard = out_valid & out_ctrl.memread & (out_rd != 0) & ((dec_use_rs1 & in rs1 == out_rd) | (dec_use_rs2 & in rs2 == out_rd)), where dec_use_rs* is decoded from in_instr.
- Input handshakes:
  - in_ready = (!out_valid | out_ready) & !hazard & !flush & !rst.
  - fire_in = in_valid & in_ready.
- Register update priority: rst > flush > fire_in (load new) > fire_out (out_valid<=0) > hold.
- Load-use case: when the load fires while the dependent instruction is blocked, out_valid goes to 0 for one cycle (bubble). The dependent instruction is accepted on the following cycle, giving exactly one bubble.
- stall_cnt increments on every cycle with in_valid & hazard & !flush and saturates at all-ones. It is cleared only by rst.
- flush: out_valid<=0 at the next edge. Any offered instruction is not accepted. stall_cnt is unaffected.
- Decode: all control defaults are 0, then by opcode:
  - OP (0110011): use_rs1, use_rs2, regwrite, memtoreg=10. aluop by funct3: 000 ADD=0000 / SUB=0001 (funct7=0100000), 001 SLL=0101, 010 SLT=1000, 011 SLTU=1001, 100 XOR=0010, 101 SRL=0110 / SRA=0111, 110 OR=0011, 111 AND=0100.
  - OP with funct7=0000001: if HAS_MEXT, aluop={1'b1,1'b0,funct3} (10000..10111) and is_mdu=1; otherwise illegal.
  - OP, any other funct7: illegal.
  - OP-IMM (0010011): as OP but immsrc=1, use_rs2=0, and no SUB. Shift funct7 other than 0000000/0100000 is illegal.
  - BRANCH (1100011): use_rs1, use_rs2, isbranch. aluop=1001 for funct3 11x, else 1000. funct3 010/011 is illegal.
  - LOAD (0000011): use_rs1, regwrite, immsrc, memread, memtoreg=01.
  - STORE (0100011): use_rs1, use_rs2, immsrc, memwrite.
  - JAL (1101111): isjump, regwrite, immsrc.
  - JALR (1100111): use_rs1, isjump, regwrite, immsrc, pcsel.
  - LUI (0110111): islui, regwrite, immsrc, memtoreg=10.
  - AUIPC (0010111): rdsel, regwrite, immsrc.
- Illegal opcode or encoding: out_ctrl=0, out_aluop=0, out_illegal=1. The instruction still passes as valid so the downstream trap logic can act.
- regwrite is forced to 0 when rd==0.
- Immediate by format: I (OP-IMM/LOAD/JALR), S, B, U (LUI/AUIPC), J (JAL); R-type gives 0. All formats sign-extend bit 31 to XLEN.
- ALU op codes narrower than ALUOP_W are zero-extended.

Test Plan:
1. Reset, then 0x002081B3 (add x3,x1,x2) at in_pc=0x100, out_ready=1 -> next cycle: out_valid=1, aluop=0, regwrite=1, memtoreg=10, rs1=1, rs2=2, rd=3, out_pc=0x100.
2. 0x0080A283 (lw x5,8(x1)) then 0x00528333 (add x6,x5,x5), out_ready=1:
   - imm=8, memread=1, memtoreg=01.
   - in_ready=0 for one cycle with stall_cnt=1, then out_valid=0 for one cycle (bubble), then the add appears.
3. 0x022081B3 (mul x3,x1,x2): HAS_MEXT=1 -> aluop=10000, is_mdu=1. HAS_MEXT=0 -> out_illegal=1, out_ctrl=0.
4. 0xFE000EE3 (beq x0,x0,-4) -> out_imm=0xFFFFFFFC, isbranch=1, aluop=1000.
5. out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0. Raise flush -> out_valid=0 next cycle and the offered instruction is not accepted.
6. rst asserted mid-stall with out_valid=1 -> all outputs 0 and stall_cnt=0 after the edge. 0x00000013 with rd=0 -> regwrite=0.
